// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter that shares one memory request port
//                between an instruction-fetch requester (0) and a load/store
//                requester (1). An in-order tag FIFO remembers who issued each
//                outstanding request so in-order responses can be routed back.
//                Requester 0 responses can be discarded on a fetch redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int REQ_W   = 66,
  parameter int RSP_W   = 32,
  parameter int MAX_OUT = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  // requester 0 (instruction fetch)
  input  logic             i_req0_valid,
  input  logic [REQ_W-1:0] i_req0_pkt,
  output logic             o_req0_ready,
  // requester 1 (load/store unit)
  input  logic             i_req1_valid,
  input  logic [REQ_W-1:0] i_req1_pkt,
  output logic             o_req1_ready,
  // shared memory request port
  output logic             o_mem_valid,
  output logic [REQ_W-1:0] o_mem_pkt,
  input  logic             i_mem_ready,
  // memory response port (in request order)
  input  logic             i_mem_rsp_valid,
  input  logic [RSP_W-1:0] i_mem_rsp_data,
  output logic             o_mem_rsp_ready,
  // routed responses
  output logic             o_rsp0_valid,
  output logic [RSP_W-1:0] o_rsp0_data,
  input  logic             i_rsp0_ready,
  output logic             o_rsp1_valid,
  output logic [RSP_W-1:0] o_rsp1_data,
  input  logic             i_rsp1_ready,
  // fetch redirect: drop every in-flight requester 0 response
  input  logic             i_flush0
);

  // Pointer needs at least one bit even for a single-entry FIFO.
  localparam int c_PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(MAX_OUT - 1);
  localparam logic [c_CNT_W-1:0] c_MAX_CNT  = c_CNT_W'(MAX_OUT);

  // Tag FIFO state: one id bit and one discard bit per entry.
  logic [MAX_OUT-1:0] r_tag_id;
  logic [MAX_OUT-1:0] r_tag_disc;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  // Requester granted by the most recent memory handshake (1 = requester 1).
  logic               r_last;

  logic w_can_issue;
  logic w_sel0;
  logic w_sel1;
  logic w_push;
  logic w_push_id;
  logic w_pop;
  logic w_empty;
  logic w_head_id;
  logic w_head_disc;

  // Wrap-around increment for FIFO pointers (depth need not be a power of 2).
  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    f_next = (p == c_LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Request path: purely combinational, so arbitration costs no cycles.
  // ---------------------------------------------------------------------------
  // Occupancy is checked before any same-cycle pop, so a full FIFO always
  // blocks the grant even when a response is retiring that cycle.
  assign w_can_issue = (r_count < c_MAX_CNT);

  // On a tie the requester that did not win the last handshake goes next.
  assign w_sel0 = i_req0_valid & (~i_req1_valid | r_last);
  assign w_sel1 = i_req1_valid & (~i_req0_valid | ~r_last);

  assign o_mem_valid  = (w_sel0 | w_sel1) & w_can_issue;
  assign o_mem_pkt    = w_sel1 ? i_req1_pkt : i_req0_pkt;
  assign o_req0_ready = w_sel0 & i_mem_ready & w_can_issue;
  assign o_req1_ready = w_sel1 & i_mem_ready & w_can_issue;

  assign w_push    = o_mem_valid & i_mem_ready;
  assign w_push_id = w_sel1;

  // ---------------------------------------------------------------------------
  // Response path: routed straight from the FIFO head, no storage added.
  // ---------------------------------------------------------------------------
  assign w_empty     = (r_count == '0);
  assign w_head_id   = r_tag_id[r_rd_ptr];
  assign w_head_disc = r_tag_disc[r_rd_ptr];

  assign o_rsp0_data = i_mem_rsp_data;
  assign o_rsp1_data = i_mem_rsp_data;

  // Steer the response to its owner; empty FIFO or discarded head sinks it.
  always_comb begin
    o_rsp0_valid    = 1'b0;
    o_rsp1_valid    = 1'b0;
    o_mem_rsp_ready = 1'b1;
    if (!w_empty && !w_head_disc) begin
      if (w_head_id) begin
        o_rsp1_valid    = i_mem_rsp_valid;
        o_mem_rsp_ready = i_rsp1_ready;
      end else begin
        o_rsp0_valid    = i_mem_rsp_valid;
        o_mem_rsp_ready = i_rsp0_ready;
      end
    end
  end

  // Only a response that belongs to an outstanding tag retires the head.
  assign w_pop = i_mem_rsp_valid & o_mem_rsp_ready & ~w_empty;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and round-robin history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_next(r_wr_ptr);
        r_last   <= w_push_id;
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag entries: write on handshake; a flush marks every requester 0 entry,
  // including one being written in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag_id   <= '0;
      r_tag_disc <= '0;
    end else begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
          r_tag_id[i]   <= w_push_id;
          r_tag_disc[i] <= i_flush0 & ~w_push_id;
        end else if (i_flush0 && !r_tag_id[i]) begin
          r_tag_disc[i] <= 1'b1;
        end
      end
    end
  end

  // A response with nothing outstanding is a protocol error upstream.
  always_ff @(posedge i_clk) begin
    assert (i_rst || !(i_mem_rsp_valid && w_empty))
      else $error("arbiter orphan response");
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed scoreboard bench for mem_port_arbiter. Stimulus
//                pushes expected grants/responses into queues; a negedge
//                monitor pops and compares whenever the DUT hands off data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int REQ_W   = 66;
  localparam int RSP_W   = 32;
  localparam int MAX_OUT = 3;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_req0_valid;
  logic [REQ_W-1:0] i_req0_pkt;
  logic             o_req0_ready;
  logic             i_req1_valid;
  logic [REQ_W-1:0] i_req1_pkt;
  logic             o_req1_ready;
  logic             o_mem_valid;
  logic [REQ_W-1:0] o_mem_pkt;
  logic             i_mem_ready;
  logic             i_mem_rsp_valid;
  logic [RSP_W-1:0] i_mem_rsp_data;
  logic             o_mem_rsp_ready;
  logic             o_rsp0_valid;
  logic [RSP_W-1:0] o_rsp0_data;
  logic             i_rsp0_ready;
  logic             o_rsp1_valid;
  logic [RSP_W-1:0] o_rsp1_data;
  logic             i_rsp1_ready;
  logic             i_flush0;

  mem_port_arbiter #(
    .REQ_W  (REQ_W),
    .RSP_W  (RSP_W),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req0_valid   (i_req0_valid),
    .i_req0_pkt     (i_req0_pkt),
    .o_req0_ready   (o_req0_ready),
    .i_req1_valid   (i_req1_valid),
    .i_req1_pkt     (i_req1_pkt),
    .o_req1_ready   (o_req1_ready),
    .o_mem_valid    (o_mem_valid),
    .o_mem_pkt      (o_mem_pkt),
    .i_mem_ready    (i_mem_ready),
    .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data (i_mem_rsp_data),
    .o_mem_rsp_ready(o_mem_rsp_ready),
    .o_rsp0_valid   (o_rsp0_valid),
    .o_rsp0_data    (o_rsp0_data),
    .i_rsp0_ready   (i_rsp0_ready),
    .o_rsp1_valid   (o_rsp1_valid),
    .o_rsp1_data    (o_rsp1_data),
    .i_rsp1_ready   (i_rsp1_ready),
    .i_flush0       (i_flush0)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  logic [REQ_W-1:0] exp_grant_q[$];
  logic [RSP_W-1:0] exp_rsp0_q[$];
  logic [RSP_W-1:0] exp_rsp1_q[$];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [95:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // Scoreboard monitor: mid-cycle, compare every handshake against the queues.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_mem_valid && i_mem_ready) begin
        if (exp_grant_q.size() == 0) unexpected("grant_unexpected", o_mem_pkt);
        else check("grant_pkt", o_mem_pkt, exp_grant_q.pop_front());
      end
      if (o_rsp0_valid && i_rsp0_ready) begin
        if (exp_rsp0_q.size() == 0) unexpected("rsp0_unexpected", o_rsp0_data);
        else check("rsp0_data", o_rsp0_data, exp_rsp0_q.pop_front());
      end
      if (o_rsp1_valid && i_rsp1_ready) begin
        if (exp_rsp1_q.size() == 0) unexpected("rsp1_unexpected", o_rsp1_data);
        else check("rsp1_data", o_rsp1_data, exp_rsp1_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_req0_valid    = 1'b0;
    i_req1_valid    = 1'b0;
    i_mem_ready     = 1'b1;
    i_mem_rsp_valid = 1'b0;
    i_rsp0_ready    = 1'b1;
    i_rsp1_ready    = 1'b1;
    i_flush0        = 1'b0;
  endtask

  // Present one memory response for a single cycle.
  task automatic respond(input logic [RSP_W-1:0] d);
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = d;
    step();
    i_mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [REQ_W-1:0] P0 = 66'h1_0000_0000_0000_0A00;
  localparam logic [REQ_W-1:0] P1 = 66'h2_0000_0000_0000_0B00;

  initial begin
    i_rst          = 1'b1;
    i_req0_pkt     = '0;
    i_req1_pkt     = '0;
    i_mem_rsp_data = '0;
    idle();

    // ---- reset state ----
    repeat (2) step();
    mid();
    check("rst_mem_valid", o_mem_valid, 0);
    check("rst_req0_ready", o_req0_ready, 0);
    check("rst_req1_ready", o_req1_ready, 0);
    check("rst_rsp0_valid", o_rsp0_valid, 0);
    check("rst_rsp1_valid", o_rsp1_valid, 0);
    check("rst_mem_rsp_ready", o_mem_rsp_ready, 1);
    step();
    i_rst = 1'b0;
    mid();
    check("idle_mem_valid", o_mem_valid, 0);
    check("idle_mem_rsp_ready", o_mem_rsp_ready, 1);
    step();

    // ---- alternation: grants 0,1,0,1, responses one cycle later ----
    exp_grant_q.push_back(P0); exp_grant_q.push_back(P1);
    exp_grant_q.push_back(P0); exp_grant_q.push_back(P1);
    exp_rsp0_q.push_back(32'hD000_0000); exp_rsp1_q.push_back(32'hD000_0001);
    exp_rsp0_q.push_back(32'hD000_0002); exp_rsp1_q.push_back(32'hD000_0003);
    i_req0_pkt = P0;
    i_req1_pkt = P1;
    for (int k = 0; k < 5; k++) begin
      i_req0_valid    = (k < 4);
      i_req1_valid    = (k < 4);
      i_mem_rsp_valid = (k >= 1);
      i_mem_rsp_data  = 32'hD000_0000 + 32'(k - 1);
      mid();
      if (k < 4) check("alt_req0_ready", o_req0_ready, (k % 2) == 0);
      step();
    end
    idle();
    step();

    // ---- fill: three requester 1 requests accepted, then blocked ----
    i_req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) exp_grant_q.push_back(66'h3_0000_0000_0000_1000 + 66'(k));
    for (int k = 0; k < 5; k++) begin
      i_req1_pkt = 66'h3_0000_0000_0000_1000 + 66'(k < 3 ? k : 3);
      mid();
      check("fill_req1_ready", o_req1_ready, k < 3);
      step();
    end
    // ---- full FIFO: pop and request in same cycle -> blocked this cycle ----
    exp_rsp1_q.push_back(32'hE000_0000);
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = 32'hE000_0000;
    mid();
    check("fullpop_req1_ready", o_req1_ready, 0);
    check("fullpop_mem_valid", o_mem_valid, 0);
    step();
    i_mem_rsp_valid = 1'b0;
    exp_grant_q.push_back(66'h3_0000_0000_0000_1003);
    mid();
    check("after_pop_req1_ready", o_req1_ready, 1);
    step();
    i_req1_pkt = 66'h3_0000_0000_0000_1004;
    mid();
    check("refull_req1_ready", o_req1_ready, 0);
    step();
    idle();
    for (int k = 1; k < 4; k++) exp_rsp1_q.push_back(32'hE000_0000 + 32'(k));
    for (int k = 1; k < 4; k++) respond(32'hE000_0000 + 32'(k));
    step();

    // ---- memory stall keeps the grant pending and r_last unchanged ----
    i_req0_pkt   = 66'h0_0000_0000_0000_2000;
    i_req1_pkt   = 66'h0_0000_0000_0000_2001;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    i_mem_ready  = 1'b0;
    mid();
    check("stall_mem_valid", o_mem_valid, 1);
    check("stall_req0_ready", o_req0_ready, 0);
    check("stall_req1_ready", o_req1_ready, 0);
    step();
    // ---- tags {0,1}, requester 0 backpressure holds the response ----
    i_mem_ready = 1'b1;
    exp_grant_q.push_back(66'h0_0000_0000_0000_2000);
    exp_grant_q.push_back(66'h0_0000_0000_0000_2001);
    step();
    i_req0_valid = 1'b0;
    step();
    idle();
    i_rsp0_ready    = 1'b0;
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = 32'hF000_0000;
    for (int k = 0; k < 3; k++) begin
      mid();
      check("bp_mem_rsp_ready", o_mem_rsp_ready, 0);
      check("bp_rsp0_valid", o_rsp0_valid, 1);
      check("bp_rsp0_data", o_rsp0_data, 32'hF000_0000);
      step();
    end
    i_rsp0_ready = 1'b1;
    exp_rsp0_q.push_back(32'hF000_0000);
    step();
    exp_rsp1_q.push_back(32'hF000_0001);
    respond(32'hF000_0001);
    step();

    // ---- tags {0,0,1}, flush drops both requester 0 responses ----
    exp_grant_q.push_back(66'h0_0000_0000_0000_3000);
    exp_grant_q.push_back(66'h0_0000_0000_0000_3001);
    exp_grant_q.push_back(66'h0_0000_0000_0000_3002);
    i_req0_valid = 1'b1;
    i_req0_pkt   = 66'h0_0000_0000_0000_3000;
    step();
    i_req0_pkt   = 66'h0_0000_0000_0000_3001;
    step();
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b1;
    i_req1_pkt   = 66'h0_0000_0000_0000_3002;
    step();
    i_req1_valid = 1'b0;
    i_flush0     = 1'b1;
    step();
    i_flush0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_mem_rsp_valid = 1'b1;
      i_mem_rsp_data  = 32'hA000_0000 + 32'(k);
      mid();
      check("flush_drop_ready", o_mem_rsp_ready, 1);
      check("flush_drop_rsp0_valid", o_rsp0_valid, 0);
      step();
    end
    exp_rsp1_q.push_back(32'hA000_0002);
    respond(32'hA000_0002);

    // ---- flush in the same cycle as a requester 0 grant ----
    exp_grant_q.push_back(66'h0_0000_0000_0000_4000);
    exp_grant_q.push_back(66'h0_0000_0000_0000_4001);
    i_req0_valid = 1'b1;
    i_req0_pkt   = 66'h0_0000_0000_0000_4000;
    i_flush0     = 1'b1;
    step();
    i_flush0   = 1'b0;
    i_req0_pkt = 66'h0_0000_0000_0000_4001;
    step();
    i_req0_valid    = 1'b0;
    i_mem_rsp_valid = 1'b1;
    i_mem_rsp_data  = 32'hB000_0000;
    mid();
    check("grantflush_rsp0_valid", o_rsp0_valid, 0);
    check("grantflush_ready", o_mem_rsp_ready, 1);
    step();
    exp_rsp0_q.push_back(32'hB000_0001);
    respond(32'hB000_0001);
    step();

    // ---- reset with two outstanding abandons the tags ----
    exp_grant_q.push_back(66'h0_0000_0000_0000_5000);
    exp_grant_q.push_back(66'h0_0000_0000_0000_5001);
    i_req1_valid = 1'b1;
    i_req1_pkt   = 66'h0_0000_0000_0000_5000;
    step();
    i_req1_pkt = 66'h0_0000_0000_0000_5001;
    step();
    i_req1_valid = 1'b0;
    i_rst        = 1'b1;
    step();
    i_rst        = 1'b0;
    i_rsp1_ready = 1'b0;
    mid();
    check("postrst_mem_rsp_ready", o_mem_rsp_ready, 1);
    step();
    i_rsp1_ready = 1'b1;
    i_req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) exp_grant_q.push_back(66'h0_0000_0000_0000_6000 + 66'(k));
    for (int k = 0; k < 4; k++) begin
      i_req1_pkt = 66'h0_0000_0000_0000_6000 + 66'(k < 3 ? k : 3);
      mid();
      check("postrst_req1_ready", o_req1_ready, k < 3);
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) exp_rsp1_q.push_back(32'hC000_0000 + 32'(k));
    for (int k = 0; k < 3; k++) respond(32'hC000_0000 + 32'(k));
    step();

    // ---- everything expected must have been observed ----
    check("grant_q_drained", 96'(exp_grant_q.size()), 0);
    check("rsp0_q_drained", 96'(exp_rsp0_q.size()), 0);
    check("rsp1_q_drained", 96'(exp_rsp1_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
